// File: rtl/ctrl_mc_pkg.sv
// Shared definitions for the multi-channel program sequencer: opcodes,
// FSM state encoding and instruction field positions.
package ctrl_mc_pkg;

  localparam logic [7:0] OP_REGWI = 8'h19;
  localparam logic [7:0] OP_SET   = 8'h51;
  localparam logic [7:0] OP_PUSH  = 8'h10;
  localparam logic [7:0] OP_LOOP  = 8'h20;
  localparam logic [7:0] OP_JNZ   = 8'h21;
  localparam logic [7:0] OP_END   = 8'h3F;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PC_RST = 4'd1,
    S_WAIT   = 4'd2,
    S_FETCH  = 4'd3,
    S_DECODE = 4'd4,
    S_REGWI  = 4'd5,
    S_SET    = 4'd6,
    S_PUSH   = 4'd7,
    S_LOOP   = 4'd8,
    S_JNZ    = 4'd9,
    S_ERR    = 4'd10,
    S_END    = 4'd11
  } state_t;

  localparam int OPC_LSB   = 56;
  localparam int CH_LSB    = 53;
  localparam int OPER_LSB  = 35;
  localparam int OPER_W    = 18;
  localparam int WADDR_LSB = 41;
  localparam int RA_W      = 5;
  localparam int N_RD      = 7;
  localparam int RADDR_W   = N_RD * RA_W;
  localparam int IMM_W     = 32;

endpackage

// File: rtl/ctrl_regfile_7r1w.sv
// Register file with seven combinational read ports and one synchronous write port.
// Read port 0 occupies the most significant slice of raddr/rdata.
module ctrl_regfile_7r1w
  import ctrl_mc_pkg::*;
#(
  parameter int B     = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [B-1:0]        wdata,
  input  logic [N_RD*AW-1:0]  raddr,
  output logic [N_RD*B-1:0]   rdata
);

  logic [B-1:0] mem_r [DEPTH];

  // Storage: cleared by reset, otherwise written on we.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {B{1'b0}};
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports: a same-cycle write is not visible until the next cycle.
  always_comb begin
    rdata = {(N_RD*B){1'b0}};
    for (int i = 0; i < N_RD; i++) begin
      rdata[(N_RD-1-i)*B +: B] = mem_r[raddr[(N_RD-1-i)*AW +: AW]];
    end
  end

endmodule

// File: rtl/ctrl_mc.sv
// Multi-channel program sequencer: fetches 64-bit instructions, writes the register
// file, issues cfg words to N_CH engines, pushes FIFO descriptors, and runs one hardware loop.
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int PMEM_N = 10,
  parameter int N_CH   = 4,
  parameter int B      = 32,
  parameter int FW     = 18 + 7 * B,
  parameter int LOOP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PMEM_N-1:0] pmem_addr,
  input  logic [63:0]       pmem_do,
  output logic [N_CH-1:0]   cfg_valid,
  output logic [FW-1:0]     cfg_data,
  input  logic [N_CH-1:0]   cfg_ready,
  output logic              fifo_wr_en,
  output logic [2*B-1:0]    fifo_di,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PCW = PMEM_N - 3;
  localparam logic [PCW-1:0]    PC_ONE   = PCW'(1);
  localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);

  state_t              state_r;
  logic [PCW-1:0]      pc_r;
  logic [63:0]         ir_r;
  logic [LOOP_W-1:0]   loop_cnt_r;
  logic                err_r;

  logic [7:0]          opcode_s;
  logic [2:0]          ch_s;
  logic [OPER_W-1:0]   oper_s;
  logic [RADDR_W-1:0]  raddr_s;
  logic [RA_W-1:0]     waddr_s;
  logic [IMM_W-1:0]    imm_s;
  logic [PCW-1:0]      target_s;
  logic [N_RD*B-1:0]   rdata_s;
  logic                ch_bad_s;
  logic                cfg_accept_s;

  assign opcode_s = ir_r[OPC_LSB +: 8];
  assign ch_s     = ir_r[CH_LSB +: 3];
  assign oper_s   = ir_r[OPER_LSB +: OPER_W];
  assign raddr_s  = ir_r[RADDR_W-1:0];
  assign waddr_s  = ir_r[WADDR_LSB +: RA_W];
  assign imm_s    = ir_r[IMM_W-1:0];
  assign target_s = imm_s[PCW-1:0];
  assign ch_bad_s = (32'(ch_s) >= N_CH);

  ctrl_regfile_7r1w #(
    .B     (B),
    .DEPTH (32),
    .AW    (RA_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (state_r == S_REGWI),
    .waddr (waddr_s),
    .wdata (imm_s[B-1:0]),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Channel request decode; only the addressed channel sees valid while in SET.
  always_comb begin
    cfg_valid = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cfg_valid[i] = (state_r == S_SET) && (ch_s == 3'(i));
    end
  end

  assign cfg_accept_s = |(cfg_valid & cfg_ready);
  assign cfg_data     = {oper_s, rdata_s};
  assign fifo_di      = rdata_s[N_RD*B-1 -: 2*B];
  assign fifo_wr_en   = (state_r == S_PUSH) && !fifo_full;
  assign pmem_addr    = {pc_r, 3'b000};
  assign busy         = (state_r != S_IDLE) && (state_r != S_END);
  assign done         = (state_r == S_END) && !err_r;
  assign err          = err_r;

  // Sequencer FSM; ir is frozen in SET/PUSH so cfg_data and fifo_di hold steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      pc_r       <= {PCW{1'b0}};
      ir_r       <= 64'd0;
      loop_cnt_r <= {LOOP_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            err_r   <= 1'b0;
            state_r <= S_PC_RST;
          end
        end
        S_PC_RST: begin
          pc_r    <= {PCW{1'b0}};
          state_r <= S_WAIT;
        end
        S_WAIT: state_r <= S_FETCH;
        S_FETCH: begin
          ir_r    <= pmem_do;
          pc_r    <= pc_r + PC_ONE;
          state_r <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode_s)
            OP_REGWI: state_r <= S_REGWI;
            OP_SET:   state_r <= ch_bad_s ? S_ERR : S_SET;
            OP_PUSH:  state_r <= S_PUSH;
            OP_LOOP:  state_r <= S_LOOP;
            OP_JNZ:   state_r <= S_JNZ;
            OP_END:   state_r <= S_END;
            default:  state_r <= S_ERR;
          endcase
        end
        // The next word was addressed during DECODE, so it can be latched here directly.
        S_REGWI: begin
          ir_r    <= pmem_do;
          pc_r    <= pc_r + PC_ONE;
          state_r <= S_DECODE;
        end
        S_SET: begin
          if (cfg_accept_s) state_r <= S_FETCH;
        end
        S_PUSH: begin
          if (!fifo_full) state_r <= S_FETCH;
        end
        S_LOOP: begin
          loop_cnt_r <= imm_s[LOOP_W-1:0];
          state_r    <= S_FETCH;
        end
        S_JNZ: begin
          if (loop_cnt_r != {LOOP_W{1'b0}}) begin
            loop_cnt_r <= loop_cnt_r - LOOP_ONE;
            pc_r       <= target_s;
            state_r    <= S_WAIT;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_ERR: begin
          err_r   <= 1'b1;
          state_r <= S_END;
        end
        S_END: begin
          if (!start) state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: an instruction-level interpreter predicts cfg
// transactions and FIFO pushes; a monitor pops and compares them as the DUT presents them.
module tb_ctrl_mc;
  import ctrl_mc_pkg::*;

  localparam int PMEM_N = 10;
  localparam int N_CH   = 4;
  localparam int B      = 32;
  localparam int FW     = 18 + 7 * B;
  localparam int LOOP_W = 16;
  localparam int PCW    = PMEM_N - 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PMEM_N-1:0] pmem_addr;
  logic [63:0]       pmem_do = 64'd0;
  logic [N_CH-1:0]   cfg_valid;
  logic [FW-1:0]     cfg_data;
  logic [N_CH-1:0]   cfg_ready = '0;
  logic              fifo_wr_en;
  logic [2*B-1:0]    fifo_di;
  logic              fifo_full = 1'b0;
  logic              busy, done, err;

  always #5 clk = ~clk;

  ctrl_mc #(.PMEM_N(PMEM_N), .N_CH(N_CH), .B(B), .FW(FW), .LOOP_W(LOOP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pmem_addr(pmem_addr), .pmem_do(pmem_do),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_di(fifo_di), .fifo_full(fifo_full),
    .busy(busy), .done(done), .err(err));

  logic [63:0] mem [2**PCW];
  always @(posedge clk) pmem_do <= mem[pmem_addr[PMEM_N-1:3]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [N_CH+FW-1:0] exp_cfg_q [$];
  logic [2*B-1:0]     exp_push_q [$];
  logic [B-1:0]       mregs [32];
  logic [LOOP_W-1:0]  mloop = '0;
  int rdy_mode = 0, rdy_delay = 0, hold_exp = 0, full_until = 0, wr_first = -1;
  bit rnd_full = 1'b0;

  function automatic void check(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Input driver: cfg_ready / fifo_full change just after the active edge.
  initial begin
    int vcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cfg_valid == '0) vcnt = 0;
      case (rdy_mode)
        0: cfg_ready = N_CH'($urandom);
        1: cfg_ready = (vcnt >= rdy_delay) ? '1 : '0;
        default: cfg_ready = '0;
      endcase
      if (cfg_valid != '0) vcnt++;
      fifo_full = (cyc < full_until) || (rnd_full && ($urandom_range(0, 2) == 0));
    end
  end

  // Monitor: compares each presented cfg word and each FIFO push against the queues.
  initial begin
    int vcyc = 0;
    forever begin
      @(negedge clk);
      if (cfg_valid != '0) begin
        if (vcyc == 0) begin
          if (exp_cfg_q.size() == 0) check("cfg_unexpected", {cfg_valid, cfg_data}, '0);
          else check("cfg_first", {cfg_valid, cfg_data}, exp_cfg_q[0]);
        end
        vcyc++;
        if ((cfg_valid & cfg_ready) != '0) begin
          if (exp_cfg_q.size() != 0) check("cfg_accept", {cfg_valid, cfg_data}, exp_cfg_q.pop_front());
          if (hold_exp > 0) check("cfg_hold", vcyc, hold_exp);
        end
      end else begin
        vcyc = 0;
      end
      if (fifo_wr_en) begin
        check("wr_while_full", fifo_full, 1'b0);
        if (wr_first < 0) wr_first = cyc;
        if (exp_push_q.size() == 0) check("push_unexpected", fifo_di, '0);
        else check("push_data", fifo_di, exp_push_q.pop_front());
      end
    end
  end

  // Instruction-level reference interpreter.
  task automatic model(output bit m_err, output bit m_done);
    logic [PCW-1:0] pc = '0;
    logic [63:0] w;
    logic [7*B-1:0] rd;
    m_err = 1'b0;
    m_done = 1'b0;
    for (int step = 0; step < 5000 && !m_err && !m_done; step++) begin
      w = mem[pc];
      case (w[63:56])
        OP_REGWI: begin mregs[w[45:41]] = w[31:0]; pc++; end
        OP_SET: begin
          if (int'(w[55:53]) >= N_CH) m_err = 1'b1;
          else begin
            rd = '0;
            for (int i = 0; i < 7; i++) rd = {rd[6*B-1:0], mregs[w[34-5*i -: 5]]};
            exp_cfg_q.push_back({N_CH'(1) << w[55:53], w[52:35], rd});
            pc++;
          end
        end
        OP_PUSH: begin exp_push_q.push_back({mregs[w[34:30]], mregs[w[29:25]]}); pc++; end
        OP_LOOP: begin mloop = w[15:0]; pc++; end
        OP_JNZ: begin
          if (mloop != '0) begin mloop--; pc = w[PCW-1:0]; end
          else pc++;
        end
        OP_END: m_done = 1'b1;
        default: m_err = 1'b1;
      endcase
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2**PCW; i++) mem[i] = {OP_END, 56'd0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mloop = '0;
    exp_cfg_q.delete();
    exp_push_q.delete();
  endtask

  task automatic run_prog(string nm, bit drop_early);
    bit me, md;
    int n = 0;
    model(me, md);
    wr_first = -1;
    @(negedge clk);
    start = 1'b1;
    if (drop_early) begin
      repeat (2) @(negedge clk);
      start = 1'b0;
    end
    while (!busy && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual=busy required=END within 4000 cycles", nm);
      do_reset();
      return;
    end
    check({nm, "_done"}, done, md);
    check({nm, "_err"}, err, me);
    check({nm, "_cfg_left"}, exp_cfg_q.size(), 0);
    check({nm, "_push_left"}, exp_push_q.size(), 0);
    exp_cfg_q.delete();
    exp_push_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    check({nm, "_idle"}, {busy, done, err}, {1'b0, 1'b0, me});
  endtask

  function automatic logic [63:0] regwi(logic [4:0] wa, logic [31:0] imm);
    logic [63:0] w = {OP_REGWI, 56'd0};
    w[45:41] = wa;
    w[31:0] = imm;
    return w;
  endfunction

  function automatic logic [63:0] rnd_ins(int k);
    logic [63:0] w = {$urandom, $urandom};
    case (k)
      0: w[63:56] = OP_REGWI;
      1: begin
        w[63:56] = OP_SET;
        w[55:53] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      end
      default: w[63:56] = OP_PUSH;
    endcase
    return w;
  endfunction

  task automatic gen_prog();
    int p = 0, bs;
    logic [63:0] w;
    logic [7:0] op;
    clear_mem();
    for (int b = 0; b < int'($urandom_range(3, 8)); b++) begin
      int kind = int'($urandom_range(0, 19));
      if (kind <= 13) begin
        mem[p] = rnd_ins(kind % 3); p++;
      end else if (kind <= 18) begin
        w = {$urandom, $urandom}; w[63:56] = OP_LOOP; w[15:0] = 16'($urandom_range(0, 3));
        mem[p] = w; p++;
        bs = p;
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin mem[p] = rnd_ins(int'($urandom_range(0, 2))); p++; end
        w = {$urandom, $urandom}; w[63:56] = OP_JNZ; w[PCW-1:0] = PCW'(bs);
        mem[p] = w; p++;
      end else begin
        do op = 8'($urandom);
        while (op == OP_REGWI || op == OP_SET || op == OP_PUSH || op == OP_LOOP || op == OP_JNZ || op == OP_END);
        w = {$urandom, $urandom}; w[63:56] = op;
        mem[p] = w; p++;
      end
    end
    w = {$urandom, $urandom}; w[63:56] = OP_END;
    mem[p] = w;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    clear_mem();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pmem_addr", pmem_addr, '0);
    check("rst_outputs", {cfg_valid, fifo_wr_en, busy, done, err}, '0);
    rst = 1'b0;

    // Two REGWIs then SET ch2 with ready held off for two cycles.
    clear_mem();
    mem[0] = regwi(5'd1, 32'h10);
    mem[1] = regwi(5'd2, 32'hAB);
    mem[2] = {OP_SET, 3'd2, 18'd5, 5'd1, 5'd2, 25'd0};
    rdy_mode = 1; rdy_delay = 2; hold_exp = 3;
    run_prog("t1_set", 1'b0);
    hold_exp = 0;

    // PUSH {r0,r1} with the FIFO full for a long window.
    clear_mem();
    mem[0] = {OP_PUSH, 3'd0, 18'd0, 5'd0, 5'd1, 25'd0};
    rdy_mode = 0;
    full_until = cyc + 20;
    run_prog("t2_push", 1'b1);
    check("t2_wr_after_full", wr_first >= full_until, 1'b1);
    full_until = 0;

    // LOOP 3 around one PUSH: four pushes.
    clear_mem();
    mem[0] = {OP_LOOP, 24'd0, 32'd3};
    mem[1] = {OP_PUSH, 3'd0, 18'd0, 5'd1, 5'd2, 25'd0};
    mem[2] = {OP_JNZ, 24'd0, 32'd1};
    run_prog("t3_loop", 1'b0);

    // Illegal opcode at pc=2, followed by SET and PUSH that must never issue.
    clear_mem();
    mem[0] = regwi(5'd4, 32'h1234);
    mem[1] = regwi(5'd5, 32'h5678);
    mem[2] = {8'hFF, 56'd0};
    mem[3] = {OP_SET, 3'd1, 18'd7, 35'd0};
    mem[4] = {OP_PUSH, 56'd0};
    run_prog("t4_illegal", 1'b0);

    // SET to a channel that does not exist.
    clear_mem();
    mem[0] = {OP_SET, 3'd5, 18'd1, 35'd0};
    run_prog("t5_badch", 1'b0);

    // Reset while a SET is waiting for ready.
    clear_mem();
    mem[0] = regwi(5'd3, 32'h55);
    mem[1] = {OP_SET, 3'd0, 18'd9, 5'd3, 30'd0};
    rdy_mode = 2;
    begin
      bit me, md;
      model(me, md);
    end
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (cfg_valid == '0 && n < 50) begin @(negedge clk); n++; end
    check("t6_valid_seen", cfg_valid, 4'b0001);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("t6_after_rst", {cfg_valid, pmem_addr, busy, done, err}, '0);
    do_reset();
    clear_mem();
    mem[0] = {OP_SET, 3'd1, 18'd3, 5'd3, 30'd0};
    rdy_mode = 0;
    run_prog("t6_regs_cleared", 1'b0);

    // Randomized programs with random ready and FIFO backpressure.
    rnd_full = 1'b1;
    for (int t = 0; t < 30; t++) begin
      gen_prog();
      run_prog("rnd", 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
